// File: rtl/core_pkg.sv
// Shared core definitions: register-number type and architecturally special registers.
package core_pkg;

  typedef logic [4:0] reg_num_t;

  localparam reg_num_t REG_ZERO = 5'd0;
  localparam reg_num_t LINK_REG = 5'd31;

  function automatic logic is_zero_reg(input reg_num_t r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/sb_regfile_bits.sv
// One register file's busy vector: set/clear/clear-all plus busy lookups that treat a
// same-cycle writeback to the looked-up register as already cleared.
module sb_regfile_bits
  import core_pkg::*;
#(
  parameter int N_LOOKUP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_all,
  input  logic                    set_en,
  input  logic [4:0]              set_reg,
  input  logic                    clr_en,
  input  logic [4:0]              clr_reg,
  input  logic [N_LOOKUP*5-1:0]   look_reg,
  output logic [N_LOOKUP-1:0]     look_busy,
  output logic                    clr_was_busy
);

  logic [31:0] busy;

  // Clear before set so an issue and a writeback to the same register leave it busy.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_reg] <= 1'b0;
      if (set_en) busy[set_reg] <= 1'b1;
    end
  end

  always_comb begin
    look_busy = '0;
    for (int i = 0; i < N_LOOKUP; i++) begin
      look_busy[i] = busy[look_reg[5*i +: 5]] &&
                     !(clr_en && (clr_reg == reg_num_t'(look_reg[5*i +: 5])));
    end
  end

  assign clr_was_busy = busy[clr_reg];

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate: stalls decoded instructions on RAW/WAW hazards against
// in-flight multi-cycle writes to the general and float register files.
module issue_scoreboard
  import core_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [14:0] src_reg,
  input  logic [2:0]  src_used,
  input  logic [2:0]  src_float,
  input  logic [4:0]  dst_reg,
  input  logic        dst_general,
  input  logic        dst_float,
  input  logic        wb_valid,
  input  logic        wb_float,
  input  logic [4:0]  wb_reg,
  input  logic        flush,
  output logic [4:0]  outstanding,
  output logic        err_spurious
);

  logic [3:0] gp_hit, fp_hit;
  logic       gp_was_busy, fp_was_busy;
  logic       dst_gp_w, dst_fp_w, dst_writes;
  logic       wb_gp, wb_fp;
  logic       src_hazard, dst_hazard, full_block;
  logic       issue, inc, dec, spurious;
  logic [19:0] look_reg;

  // Both dst flags set is a decoder protocol error; the general file takes it.
  assign dst_gp_w   = dst_general && !is_zero_reg(dst_reg);
  assign dst_fp_w   = dst_float && !dst_general;
  assign dst_writes = dst_gp_w || dst_fp_w;

  assign wb_gp = wb_valid && !wb_float && !is_zero_reg(wb_reg);
  assign wb_fp = wb_valid && wb_float;

  assign look_reg = {dst_reg, src_reg};

  always_comb begin
    src_hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (src_used[i]) begin
        if (src_float[i]) src_hazard = src_hazard || fp_hit[i];
        else              src_hazard = src_hazard || (gp_hit[i] && !is_zero_reg(src_reg[5*i +: 5]));
      end
    end
  end

  assign dst_hazard = (dst_gp_w && gp_hit[3]) || (dst_fp_w && fp_hit[3]);
  assign full_block = dst_writes && (outstanding == 5'(MAX_OUTSTANDING)) && !wb_valid;
  assign dec_ready  = !src_hazard && !dst_hazard && !flush && !full_block;

  assign issue    = dec_valid && dec_ready;
  assign inc      = issue && dst_writes;
  assign dec      = (wb_gp && gp_was_busy) || (wb_fp && fp_was_busy);
  assign spurious = (wb_gp && !gp_was_busy) || (wb_fp && !fp_was_busy);

  sb_regfile_bits #(.N_LOOKUP(4)) u_gp (
    .clk          (clk),
    .rst          (rst),
    .clr_all      (flush),
    .set_en       (issue && dst_gp_w),
    .set_reg      (dst_reg),
    .clr_en       (wb_gp),
    .clr_reg      (wb_reg),
    .look_reg     (look_reg),
    .look_busy    (gp_hit),
    .clr_was_busy (gp_was_busy)
  );

  sb_regfile_bits #(.N_LOOKUP(4)) u_fp (
    .clk          (clk),
    .rst          (rst),
    .clr_all      (flush),
    .set_en       (issue && dst_fp_w),
    .set_reg      (dst_reg),
    .clr_en       (wb_fp),
    .clr_reg      (wb_reg),
    .look_reg     (look_reg),
    .look_busy    (fp_hit),
    .clr_was_busy (fp_was_busy)
  );

  // A spurious writeback decrements nothing, which is what keeps the count from underflowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding  <= '0;
      err_spurious <= 1'b0;
    end else if (flush) begin
      outstanding  <= '0;
    end else begin
      outstanding <= outstanding + 5'(inc) - 5'(dec);
      if (spurious) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: one task per scenario with hand-computed expectations.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready, dec_ready2;
  logic [14:0] src_reg;
  logic [2:0]  src_used;
  logic [2:0]  src_float;
  logic [4:0]  dst_reg;
  logic        dst_general;
  logic        dst_float;
  logic        wb_valid;
  logic        wb_float;
  logic [4:0]  wb_reg;
  logic        flush;
  logic [4:0]  outstanding, outstanding2;
  logic        err_spurious, err_spurious2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .src_reg(src_reg), .src_used(src_used), .src_float(src_float),
    .dst_reg(dst_reg), .dst_general(dst_general), .dst_float(dst_float),
    .wb_valid(wb_valid), .wb_float(wb_float), .wb_reg(wb_reg), .flush(flush),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  // Second instance with a tiny in-flight limit; shares all inputs, only checked in test_max.
  issue_scoreboard #(.MAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready2),
    .src_reg(src_reg), .src_used(src_used), .src_float(src_float),
    .dst_reg(dst_reg), .dst_general(dst_general), .dst_float(dst_float),
    .wb_valid(wb_valid), .wb_float(wb_float), .wb_reg(wb_reg), .flush(flush),
    .outstanding(outstanding2), .err_spurious(err_spurious2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; src_reg = '0; src_used = '0; src_float = '0;
    dst_reg = '0; dst_general = 0; dst_float = 0;
    wb_valid = 0; wb_float = 0; wb_reg = '0; flush = 0;
  endtask

  task automatic issue_dst(input logic [4:0] r, input logic fl);
    idle();
    dec_valid = 1; dst_reg = r; dst_general = !fl; dst_float = fl;
  endtask

  task automatic read_src(input logic [4:0] r, input logic fl);
    idle();
    src_reg[4:0] = r; src_used[0] = 1; src_float[0] = fl;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("[TB] FAIL reset_outstanding got %0d want 0", outstanding); end
    n_vec++; if (err_spurious !== 1'b0) begin n_err++; $display("[TB] FAIL reset_err got %b want 0", err_spurious); end
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready got %b want 1", dec_ready); end
  endtask

  task automatic test_raw();
    issue_dst(5'd5, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL raw_issue_ready got %b want 1", dec_ready); end
    step();
    read_src(5'd5, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("[TB] FAIL raw_stall got %b want 0", dec_ready); end
    n_vec++; if (outstanding !== 5'd1) begin n_err++; $display("[TB] FAIL raw_count1 got %0d want 1", outstanding); end
    step();
    wb_valid = 1; wb_float = 0; wb_reg = 5'd5; dec_valid = 1;
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL raw_bypass got %b want 1", dec_ready); end
    step();
    idle();
    #1;
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("[TB] FAIL raw_count0 got %0d want 0", outstanding); end
  endtask

  task automatic test_float();
    issue_dst(5'd3, 1);
    step();
    read_src(5'd3, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flt_gp_r3 got %b want 1", dec_ready); end
    read_src(5'd3, 1);
    #1;
    n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("[TB] FAIL flt_fp_f3 got %b want 0", dec_ready); end
    issue_dst(5'd0, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flt_r0_ready got %b want 1", dec_ready); end
    step();
    idle();
    #1;
    n_vec++; if (outstanding !== 5'd1) begin n_err++; $display("[TB] FAIL flt_r0_count got %0d want 1", outstanding); end
    read_src(5'd0, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flt_src_r0 got %b want 1", dec_ready); end
    idle();
    wb_valid = 1; wb_float = 1; wb_reg = 5'd3;
    step();
    idle();
    #1;
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("[TB] FAIL flt_wb_count got %0d want 0", outstanding); end
    n_vec++; if (err_spurious !== 1'b0) begin n_err++; $display("[TB] FAIL flt_err got %b want 0", err_spurious); end
  endtask

  task automatic test_max();
    do_reset();
    issue_dst(5'd1, 0);
    step();
    issue_dst(5'd2, 0);
    step();
    issue_dst(5'd4, 0);
    #1;
    n_vec++; if (outstanding2 !== 5'd2) begin n_err++; $display("[TB] FAIL max_count got %0d want 2", outstanding2); end
    n_vec++; if (dec_ready2 !== 1'b0) begin n_err++; $display("[TB] FAIL max_block got %b want 0", dec_ready2); end
    wb_valid = 1; wb_float = 0; wb_reg = 5'd1;
    #1;
    n_vec++; if (dec_ready2 !== 1'b1) begin n_err++; $display("[TB] FAIL max_wb_ready got %b want 1", dec_ready2); end
    step();
    idle();
    #1;
    n_vec++; if (outstanding2 !== 5'd2) begin n_err++; $display("[TB] FAIL max_net got %0d want 2", outstanding2); end
    read_src(5'd4, 0);
    #1;
    n_vec++; if (dec_ready2 !== 1'b0) begin n_err++; $display("[TB] FAIL max_r4_busy got %b want 0", dec_ready2); end
    read_src(5'd1, 0);
    #1;
    n_vec++; if (dec_ready2 !== 1'b1) begin n_err++; $display("[TB] FAIL max_r1_free got %b want 1", dec_ready2); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    issue_dst(5'd7, 0);
    step();
    issue_dst(5'd7, 0);
    wb_valid = 1; wb_float = 0; wb_reg = 5'd7;
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready got %b want 1", dec_ready); end
    step();
    read_src(5'd7, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_still_busy got %b want 0", dec_ready); end
    n_vec++; if (outstanding !== 5'd1) begin n_err++; $display("[TB] FAIL b2b_count got %0d want 1", outstanding); end
    idle();
    wb_valid = 1; wb_float = 0; wb_reg = 5'd9;
    step();
    idle();
    step(); step();
    n_vec++; if (err_spurious !== 1'b1) begin n_err++; $display("[TB] FAIL spur_err got %b want 1", err_spurious); end
    n_vec++; if (outstanding !== 5'd1) begin n_err++; $display("[TB] FAIL spur_count got %0d want 1", outstanding); end
    wb_valid = 1; wb_float = 0; wb_reg = 5'd7;
    step();
    idle();
    #1;
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("[TB] FAIL spur_drain got %0d want 0", outstanding); end
    n_vec++; if (err_spurious !== 1'b1) begin n_err++; $display("[TB] FAIL spur_sticky got %b want 1", err_spurious); end
  endtask

  task automatic test_flush();
    issue_dst(5'd10, 0);
    step();
    issue_dst(5'd11, 0);
    step();
    issue_dst(5'd12, 1);
    step();
    idle();
    #1;
    n_vec++; if (outstanding !== 5'd3) begin n_err++; $display("[TB] FAIL fl_pre_count got %0d want 3", outstanding); end
    issue_dst(5'd13, 0);
    flush = 1;
    #1;
    n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("[TB] FAIL fl_ready got %b want 0", dec_ready); end
    step();
    idle();
    #1;
    n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("[TB] FAIL fl_count got %0d want 0", outstanding); end
    read_src(5'd10, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL fl_r10 got %b want 1", dec_ready); end
    read_src(5'd12, 1);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL fl_f12 got %b want 1", dec_ready); end
    read_src(5'd13, 0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("[TB] FAIL fl_r13 got %b want 1", dec_ready); end
    n_vec++; if (err_spurious !== 1'b1) begin n_err++; $display("[TB] FAIL fl_err_kept got %b want 1", err_spurious); end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_raw();
    test_float();
    test_max();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
